serial_sub: RTL and testbench

Bit-serial unsigned subtractor: accepts two WIDTH-bit operands over a valid/ready handshake and computes `a - b` LSB-first, one bit per clock. It returns the difference and final borrow over a second valid/ready handshake. It is the inverse-direction companion to the team's half-adder arithmetic cells and reuses the same single-bit primitive style: the per-bit cell is built from two half-subtractors. It sits between a operand producer and a result consumer where area matters more than throughput.

---
 rtl/serial_sub_pkg.sv | 5 +
 rtl/serial_sub_half_sub.sv | 10 +
 rtl/serial_sub.sv | 55 +++++
 tb/tb_serial_sub.sv | 135 +++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: FSM state encodings and default width shared by the serial arithmetic blocks
package serial_sub_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  localparam int DEF_WIDTH = 8;
endpackage

// File: rtl/serial_sub_half_sub.sv
// half_sub: single-bit half subtractor, d = a - b, bo = borrow out
module half_sub (
  input  logic a,
  input  logic b,
  output logic d,
  output logic bo
);
  assign d  = a ^ b;
  assign bo = ~a & b;
endmodule

// File: rtl/serial_sub.sv
// serial_sub: bit-serial unsigned subtractor a - b, LSB first, valid/ready in and out
module serial_sub import serial_sub_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  state_t st;
  logic [WIDTH-1:0] sa, sb, sr;
  logic br, d1, bo1, d, bo2;
  logic [CW-1:0] cnt;
  half_sub u_h0 (.a(sa[0]), .b(sb[0]), .d(d1), .bo(bo1));
  half_sub u_h1 (.a(d1), .b(br), .d(d), .bo(bo2));
  assign in_ready  = ~rst & (st == IDLE);
  assign out_valid = st == DONE;
  assign diff      = sr;
  assign borrow    = br;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st  <= IDLE;
      sa  <= '0;
      sb  <= '0;
      sr  <= '0;
      br  <= 1'b0;
      cnt <= '0;
    end else if (st == IDLE) begin
      if (in_valid) begin
        sa  <= a;
        sb  <= b;
        br  <= 1'b0;
        cnt <= '0;
        st  <= RUN;
      end
    end else if (st == RUN) begin
      sa  <= sa >> 1;
      sb  <= sb >> 1;
      sr  <= WIDTH'({d, sr} >> 1);
      br  <= bo1 | bo2;
      cnt <= cnt + 1'b1;
      if (cnt == LAST) st <= DONE;
    end else if (out_ready) begin
      st <= IDLE;
    end
  end
endmodule

// File: tb/tb_serial_sub.sv
// tb_serial_sub: scoreboard bench for serial_sub at WIDTH=8 and WIDTH=1
module tb_serial_sub;
  logic clk = 0, rst = 1;
  logic in_valid = 0, out_ready = 1, in_ready, out_valid, borrow;
  logic [7:0] a = 0, b = 0, diff;
  logic u_in_valid = 0, u_out_ready = 1, u_in_ready, u_out_valid, u_borrow;
  logic [0:0] u_a = 0, u_b = 0, u_diff;
  int checks = 0, errors = 0;
  bit rand_rdy = 0;
  logic [8:0] q[$];
  logic [1:0] q1[$];
  always #5 clk = ~clk;
  serial_sub #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .diff(diff), .borrow(borrow));
  serial_sub #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .in_valid(u_in_valid), .in_ready(u_in_ready),
    .a(u_a), .b(u_b), .out_valid(u_out_valid), .out_ready(u_out_ready), .diff(u_diff), .borrow(u_borrow));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) if (out_valid) begin
    chk("ready_with_valid", in_ready, 0);
    if (q.size() == 0) chk("unexpected_result", 1, 0);
    else begin
      chk("result", {borrow, diff}, q[0]);
      if (out_ready) void'(q.pop_front());
    end
  end

  always @(negedge clk) if (u_out_valid) begin
    if (q1.size() == 0) chk("w1_unexpected", 1, 0);
    else begin
      chk("w1_result", {u_borrow, u_diff}, q1[0]);
      if (u_out_ready) void'(q1.pop_front());
    end
  end

  always @(posedge clk) if (rand_rdy) #1 out_ready = ($urandom_range(0, 3) != 0);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [7:0] x, input logic [7:0] y, input bit meas);
    int t = 0;
    while (!in_ready && t < 200) begin tick(); t++; end
    if (!in_ready) chk("in_ready_timeout", 0, 1);
    in_valid = 1; a = x; b = y;
    q.push_back({x < y, 8'(x - y)});
    tick();
    in_valid = 0;
    if (meas) begin
      t = 0;
      while (!out_valid && t < 50) begin tick(); t++; end
      chk("latency", t, 8);
    end
  endtask

  task automatic op1(input logic x, input logic y);
    int t = 0;
    while (!u_in_ready && t < 20) begin tick(); t++; end
    u_in_valid = 1; u_a = x; u_b = y;
    q1.push_back({x < y, x ^ y});
    tick();
    u_in_valid = 0;
    t = 0;
    while (!u_out_valid && t < 20) begin tick(); t++; end
    chk("w1_latency", t, 1);
  endtask

  initial begin
    #2;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_diff", {borrow, diff}, 0);
    tick(); tick();
    chk("rst_in_ready_held", in_ready, 0);
    rst = 0;
    #1;
    chk("in_ready_after_rst", in_ready, 1);
    op(8'h05, 8'h03, 1);
    tick();
    chk("back_to_idle", {in_ready, out_valid}, 2'b10);
    op(8'h03, 8'h05, 1);
    op(8'h00, 8'h01, 1);
    op(8'hFF, 8'hFF, 1);
    op(8'h00, 8'h00, 1);
    tick();
    out_ready = 0;
    op(8'h80, 8'h01, 0);
    in_valid = 1; a = 8'h11; b = 8'h22;
    for (int i = 0; i < 20 && !out_valid; i++) tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold", {out_valid, in_ready, borrow, diff}, {2'b10, 1'b0, 8'h7F});
      tick();
    end
    out_ready = 1;
    in_valid = 0;
    tick();
    chk("bp_drained", q.size(), 0);
    op(8'h37, 8'h12, 0);
    tick(); tick(); tick();
    rst = 1;
    #1;
    chk("abort_outs", {out_valid, in_ready}, 0);
    chk("abort_regs", {borrow, diff}, 0);
    q.delete();
    tick(); tick();
    rst = 0;
    #1;
    chk("ready_after_abort", in_ready, 1);
    op(8'h10, 8'h20, 1);
    op1(1'b0, 1'b1);
    op1(1'b1, 1'b0);
    op1(1'b1, 1'b1);
    tick();
    rand_rdy = 1;
    for (int i = 0; i < 40; i++) op(8'($urandom), 8'($urandom), 0);
    for (int i = 0; i < 200 && q.size() != 0; i++) tick();
    rand_rdy = 0;
    #2;
    out_ready = 1;
    for (int i = 0; i < 20 && q.size() != 0; i++) tick();
    chk("queue_empty", q.size(), 0);
    chk("w1_queue_empty", q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
